// File: rtl/fpga_robots_game_timebase_pkg.sv
// fpga_robots_game_timebase_pkg: config-select encodings and default rates
// shared by the timebase and the game logic that retunes it.
`default_nettype none

package fpga_robots_game_timebase_pkg;

  typedef enum logic [1:0] {
    TB_SEL_STEP = 2'd0,
    TB_SEL_DIV  = 2'd1,
    TB_SEL_CLR  = 2'd2,
    TB_SEL_RSVD = 2'd3
  } tb_sel_e;

  // 115,200 baud at a 65 MHz oclk: 65e6 * 929 / 2^19 ~= 115.17 kHz
  localparam int TB_STEP_BAUD = 929;
  localparam int TB_DIV_PS2   = 5;

  function automatic int tb_ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpga_robots_game_timebase_chan.sv
// fpga_robots_game_timebase_chan: one channel's phase accumulator, oversample
// divider and registered base/oversample/divided strobes.
`default_nettype none

module fpga_robots_game_timebase_chan #(
  parameter int               ACC_W    = 19,
  parameter int               OVS_LOG2 = 3,
  parameter int               DIV_W    = 4,
  parameter logic [ACC_W-1:0] STEP_RST = ACC_W'(929),
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_we,
  input  logic             div_we,
  input  logic             clr,
  input  logic [ACC_W-1:0] wdata,
  output logic             tick,
  output logic             tick_ovs,
  output logic             tick_div
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
  ,
  output logic             tog
`endif
);

  localparam int K = ACC_W - OVS_LOG2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] step;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] divctr;
  logic [ACC_W:0]   sum;
  logic             ovs_evt;

  assign sum     = {1'b0, acc} + {1'b0, step};
  assign ovs_evt = sum[K] ^ acc[K];

  // Later assignments win: writes override the divider update, and a clear
  // overrides both the divider and the strobes computed this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      step     <= STEP_RST;
      div      <= DIV_RST;
      divctr   <= '0;
      tick     <= 1'b0;
      tick_ovs <= 1'b0;
      tick_div <= 1'b0;
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
      tog      <= 1'b0;
`endif
    end else begin
      acc      <= sum[ACC_W-1:0];
      tick     <= sum[ACC_W];
      tick_ovs <= ovs_evt;
      tick_div <= 1'b0;
      if (ovs_evt) begin
        if (divctr == div) begin
          tick_div <= 1'b1;
          divctr   <= '0;
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
          tog      <= ~tog;
`endif
        end else begin
          divctr <= divctr + DIV_W'(1);
        end
      end
      if (step_we) begin
        step <= wdata;
      end
      if (div_we) begin
        div    <= wdata[DIV_W-1:0];
        divctr <= '0;
      end
      if (clr) begin
        acc      <= '0;
        divctr   <= '0;
        tick     <= 1'b0;
        tick_ovs <= 1'b0;
        tick_div <= 1'b0;
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
        tog      <= 1'b0;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpga_robots_game_timebase.sv
// fpga_robots_game_timebase: NCH-channel programmable strobe generator with a
// register-style config port. Optional FPGA_ROBOTS_TIMEBASE_TOGGLE_EN adds tog.
`default_nettype none

module fpga_robots_game_timebase
  import fpga_robots_game_timebase_pkg::*;
#(
  parameter int                     NCH       = 3,
  parameter int                     ACC_W     = 19,
  parameter int                     OVS_LOG2  = 3,
  parameter int                     DIV_W     = 4,
  parameter logic [NCH*ACC_W-1:0]   STEP_INIT = {3{19'd929}},
  parameter logic [NCH*DIV_W-1:0]   DIV_INIT  = {3{4'd5}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [tb_ch_width(NCH)-1:0]   cfg_ch,
  input  logic [1:0]                    cfg_sel,
  input  logic [ACC_W-1:0]              cfg_data,
  output logic                          cfg_ack,
  output logic [NCH-1:0]                tick,
  output logic [NCH-1:0]                tick_ovs,
  output logic [NCH-1:0]                tick_div
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
  ,
  output logic [NCH-1:0]                tog
`endif
);

  localparam int CH_W = tb_ch_width(NCH);

  logic sel_step;
  logic sel_div;
  logic sel_clr;

  assign sel_step = (cfg_sel == TB_SEL_STEP);
  assign sel_div  = (cfg_sel == TB_SEL_DIV);
  assign sel_clr  = (cfg_sel == TB_SEL_CLR);

  // Every write is acknowledged, including reserved selects and absent channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= cfg_we;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic hit;
    assign hit = cfg_we && (cfg_ch == CH_W'(i));

    fpga_robots_game_timebase_chan #(
      .ACC_W    (ACC_W),
      .OVS_LOG2 (OVS_LOG2),
      .DIV_W    (DIV_W),
      .STEP_RST (STEP_INIT[i*ACC_W +: ACC_W]),
      .DIV_RST  (DIV_INIT[i*DIV_W +: DIV_W])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .step_we  (hit && sel_step),
      .div_we   (hit && sel_div),
      .clr      (hit && sel_clr),
      .wdata    (cfg_data),
      .tick     (tick[i]),
      .tick_ovs (tick_ovs[i]),
      .tick_div (tick_div[i])
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
      ,
      .tog      (tog[i])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_fpga_robots_game_timebase.sv
// tb_fpga_robots_game_timebase: directed self-checking bench for the timebase.
`default_nettype none

module tb_fpga_robots_game_timebase;
  import fpga_robots_game_timebase_pkg::*;

  localparam int NCH   = 3;
  localparam int ACC_W = 19;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_sel = '0;
  logic [ACC_W-1:0] cfg_data = '0;
  logic             cfg_ack;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   tick_ovs;
  logic [NCH-1:0]   tick_div;
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
  logic [NCH-1:0]   tog;
`endif

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  fpga_robots_game_timebase dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .cfg_ack  (cfg_ack),
    .tick     (tick),
    .tick_ovs (tick_ovs),
    .tick_div (tick_div)
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
    ,
    .tog      (tog)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time expired, required finish before 3000000");
    $fatal(1, "watchdog");
  end

  task automatic clk_step;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    clk_step();
    clk_step();
    rst = 1'b0;
    edge_n = 0;
  endtask

  // True when edge k (constant step since reset) crosses a multiple of unit.
  function automatic bit exp_wrap(input int k, input longint step, input longint unit);
    return ((longint'(k) * step) / unit) != ((longint'(k - 1) * step) / unit);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) clk_step();
    checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_tick: got %b expected 000", tick); end
    checks++; if (tick_ovs !== 3'b000) begin errors++; $display("FAIL reset_ovs: got %b expected 000", tick_ovs); end
    checks++; if (tick_div !== 3'b000) begin errors++; $display("FAIL reset_div: got %b expected 000", tick_div); end
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", cfg_ack); end
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
    checks++; if (tog !== 3'b000) begin errors++; $display("FAIL reset_tog: got %b expected 000", tog); end
`endif
  endtask

  task automatic test_first_strobes;
    int ft, fo, fd, diff;
    logic t566;
    ft = -1; fo = -1; fd = -1; diff = 0; t566 = 1'bx;
    do_reset();
    while (edge_n < 600) begin
      clk_step();
      if (tick[0] && ft < 0) ft = edge_n;
      if (tick_ovs[0] && fo < 0) fo = edge_n;
      if (tick_div[0] && fd < 0) fd = edge_n;
      if (edge_n == 566) t566 = tick[0];
      if (tick[1] !== tick[0] || tick[2] !== tick[0] || tick_ovs[2] !== tick_ovs[0]) diff++;
    end
    checks++; if (ft != 565) begin errors++; $display("FAIL first_tick: got %0d expected 565", ft); end
    checks++; if (fo != 71) begin errors++; $display("FAIL first_ovs: got %0d expected 71", fo); end
    checks++; if (fd != 424) begin errors++; $display("FAIL first_div: got %0d expected 424", fd); end
    checks++; if (t566 !== 1'b0) begin errors++; $display("FAIL tick_width: got %b expected 0 at edge 566", t566); end
    checks++; if (diff != 0) begin errors++; $display("FAIL chan_equal: got %0d differing cycles expected 0", diff); end
  endtask

  task automatic test_div_ratio;
    int nt, no, nd, bad;
    nt = 0; no = 0; nd = 0; bad = 0;
    do_reset();
    repeat (10000) begin
      clk_step();
      nt += int'(tick[0]);
      no += int'(tick_ovs[0]);
      nd += int'(tick_div[0]);
      if (tick_div[0] && !tick_ovs[0]) bad++;
    end
    checks++; if (nt != 17) begin errors++; $display("FAIL ratio_tick: got %0d expected 17", nt); end
    checks++; if (no != 141) begin errors++; $display("FAIL ratio_ovs: got %0d expected 141", no); end
    checks++; if (nd != 23) begin errors++; $display("FAIL ratio_div: got %0d expected 23", nd); end
    checks++; if (bad != 0) begin errors++; $display("FAIL div_align: got %0d expected 0", bad); end
  endtask

  task automatic test_step_write;
    int m1, mo;
    m1 = 0; mo = 0;
    do_reset();
    repeat (100) clk_step();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_sel = TB_SEL_STEP; cfg_data = 19'h40000;
    clk_step();
    cfg_we = 1'b0;
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL step_ack: got %b expected 1", cfg_ack); end
    for (int j = 1; j <= 600; j++) begin
      clk_step();
      if (j == 1) begin
        checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL step_ack_drop: got %b expected 0", cfg_ack); end
      end
      if (tick[1] !== ((j % 2) == 0)) m1++;
      if (tick[0] !== exp_wrap(edge_n, 929, 64'd524288) || tick[2] !== exp_wrap(edge_n, 929, 64'd524288)) mo++;
      if (tick_ovs[0] !== exp_wrap(edge_n, 929, 64'd65536) || tick_ovs[2] !== exp_wrap(edge_n, 929, 64'd65536)) mo++;
    end
    checks++; if (m1 != 0) begin errors++; $display("FAIL ch1_half_rate: got %0d bad cycles expected 0", m1); end
    checks++; if (mo != 0) begin errors++; $display("FAIL other_chans: got %0d bad cycles expected 0", mo); end
  endtask

  task automatic test_step_zero;
    int n2, ft, fo;
    n2 = 0; ft = -1; fo = -1;
    do_reset();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = TB_SEL_STEP; cfg_data = '0;
    clk_step();
    cfg_we = 1'b0;
    repeat (5000) begin
      clk_step();
      if (tick[2] || tick_ovs[2] || tick_div[2]) n2++;
    end
    checks++; if (n2 != 0) begin errors++; $display("FAIL idle_ch2: got %0d strobes expected 0", n2); end
    cfg_we = 1'b1; cfg_sel = TB_SEL_CLR;
    clk_step();
    cfg_sel = TB_SEL_STEP; cfg_data = 19'd929;
    clk_step();
    cfg_we = 1'b0;
    for (int j = 1; j <= 1000; j++) begin
      clk_step();
      if (tick[2] && ft < 0) ft = j;
      if (tick_ovs[2] && fo < 0) fo = j;
    end
    checks++; if (ft != 565) begin errors++; $display("FAIL restart_tick: got %0d expected 565", ft); end
    checks++; if (fo != 71) begin errors++; $display("FAIL restart_ovs: got %0d expected 71", fo); end
  endtask

  task automatic test_div_zero_and_ignored;
    int acks, md, no, nd1, mt;
    acks = 0; md = 0; no = 0; nd1 = 0; mt = 0;
    do_reset();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = TB_SEL_DIV; cfg_data = '0;
    clk_step(); acks += int'(cfg_ack);
    cfg_ch = 2'd3; cfg_sel = TB_SEL_STEP;
    clk_step(); acks += int'(cfg_ack);
    cfg_ch = 2'd0; cfg_sel = TB_SEL_RSVD;
    clk_step(); acks += int'(cfg_ack);
    cfg_we = 1'b0;
    checks++; if (acks != 3) begin errors++; $display("FAIL b2b_acks: got %0d expected 3", acks); end
    while (edge_n < 2000) begin
      clk_step();
      if (tick_div[0] !== tick_ovs[0]) md++;
      no  += int'(tick_ovs[0]);
      nd1 += int'(tick_div[1]);
      for (int c = 0; c < NCH; c++)
        if (tick[c] !== exp_wrap(edge_n, 929, 64'd524288)) mt++;
    end
    checks++; if (md != 0) begin errors++; $display("FAIL div0_equal: got %0d bad cycles expected 0", md); end
    checks++; if (no != 28) begin errors++; $display("FAIL div0_ovs: got %0d expected 28", no); end
    checks++; if (nd1 != 4) begin errors++; $display("FAIL ch1_div5: got %0d expected 4", nd1); end
    checks++; if (mt != 0) begin errors++; $display("FAIL ignored_writes: got %0d bad cycles expected 0", mt); end
  endtask

  task automatic test_collisions;
    do_reset();
    repeat (70) clk_step();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = TB_SEL_CLR;
    clk_step();
    cfg_we = 1'b0;
    checks++; if (tick_ovs !== 3'b011) begin errors++; $display("FAIL clr_ovs_suppress: got %b expected 011", tick_ovs); end
    repeat (493) clk_step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = TB_SEL_CLR;
    clk_step();
    cfg_we = 1'b0;
    checks++; if (tick[1:0] !== 2'b10) begin errors++; $display("FAIL clr_tick_suppress: got %b expected 10", tick[1:0]); end
    do_reset();
    repeat (564) clk_step();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_sel = TB_SEL_STEP; cfg_data = 19'h40000;
    clk_step();
    cfg_we = 1'b0;
    checks++; if (tick[1] !== 1'b1) begin errors++; $display("FAIL write_carry: got %b expected 1", tick[1]); end
    clk_step();
    clk_step();
    checks++; if (tick[1] !== 1'b1) begin errors++; $display("FAIL new_step_carry: got %b expected 1 at edge 567", tick[1]); end
  endtask

  task automatic test_reset_mid;
    int ft;
    ft = -1;
    do_reset();
    repeat (565) clk_step();
    checks++; if (tick !== 3'b111) begin errors++; $display("FAIL pre_reset_tick: got %b expected 111", tick); end
    rst = 1'b1;
    clk_step();
    checks++; if ({tick, tick_ovs, tick_div, cfg_ack} !== 10'd0) begin
      errors++; $display("FAIL mid_reset_outs: got %b expected 0", {tick, tick_ovs, tick_div, cfg_ack});
    end
`ifdef FPGA_ROBOTS_TIMEBASE_TOGGLE_EN
    checks++; if (tog !== 3'b000) begin errors++; $display("FAIL mid_reset_tog: got %b expected 000", tog); end
`endif
    rst = 1'b0;
    edge_n = 0;
    while (edge_n < 1000 && ft < 0) begin
      clk_step();
      if (tick[0]) ft = edge_n;
    end
    checks++; if (ft != 565) begin errors++; $display("FAIL post_reset_tick: got %0d expected 565", ft); end
  endtask

  initial begin
    test_reset();
    test_first_strobes();
    test_div_ratio();
    test_step_write();
    test_step_zero();
    test_div_zero_and_ignored();
    test_collisions();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
